// File: rtl/bm_mac_pkg.sv
// Shared widths, Booth digit encoding and lane slicing helpers for the BM MAC datapath.
package bm_mac_pkg;

  // Radix-4 Booth digit of the recoded multiplier
  typedef enum logic [2:0] {
    BoothZero,
    BoothP1,
    BoothM1,
    BoothP2,
    BoothM2
  } booth_e;

  // Full signed product of two mantissas
  function automatic int unsigned prod_w(int unsigned mw);
    return 2 * mw;
  endfunction

  // Product after the largest possible exponent shift
  function automatic int unsigned shift_w(int unsigned mw, int unsigned ew);
    return prod_w(mw) + 2 * ((32'd1 << ew) - 32'd1);
  endfunction

  // Smallest accumulator that holds MAX_LEN beats of LANES products exactly
  function automatic int unsigned min_acc_w(int unsigned mw, int unsigned ew,
                                            int unsigned lanes, int unsigned max_len);
    return shift_w(mw, ew) + $clog2(lanes) + $clog2(max_len);
  endfunction

  // Number of radix-4 digits needed for an mw-bit two's complement multiplier
  function automatic int unsigned booth_digits(int unsigned mw);
    return (mw + 1) / 2;
  endfunction

  // LSB position of a lane inside a packed lane vector
  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned w);
    return lane * w;
  endfunction

  // Triplet {b[2d+1], b[2d], b[2d-1]} to Booth digit
  function automatic booth_e booth_decode(logic [2:0] bits);
    booth_e code;
    case (bits)
      3'b001, 3'b010: code = BoothP1;
      3'b011:         code = BoothP2;
      3'b100:         code = BoothM2;
      3'b101, 3'b110: code = BoothM1;
      default:        code = BoothZero;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bm_booth_lane.sv
// One lane of the dot product: radix-4 Booth recode of b, partial products of a, exponent shift.
// Negative digits are emitted one's-complemented; their +1 terms are collected in corr_o so the
// caller's carry-save tree absorbs them. All outputs are sign-extended to OW bits.
module bm_booth_lane
  import bm_mac_pkg::*;
#(
  parameter int unsigned MW = 6,
  parameter int unsigned EW = 2,
  parameter int unsigned OW = 32
) (
  input  logic [MW-1:0]                   a_i,
  input  logic [MW-1:0]                   b_i,
  input  logic [EW-1:0]                   a_exp_i,
  input  logic [EW-1:0]                   b_exp_i,
  output logic [booth_digits(MW)*OW-1:0]  pp_o,
  output logic [OW-1:0]                   corr_o
);

  localparam int unsigned NDig = booth_digits(MW);
  localparam int unsigned BW   = 2 * NDig;

  logic [BW:0]   b_pad;
  logic [EW:0]   shamt;
  logic [OW-1:0] a_ext;
  logic [OW-1:0] a_dbl;
  logic [OW-1:0] mag;
  logic [OW-1:0] pp;
  logic          neg;
  booth_e        code;

  // Recode, select multiple of a, weight by digit position and exponent sum
  always_comb begin
    b_pad  = {BW'($signed(b_i)), 1'b0};
    shamt  = {1'b0, a_exp_i} + {1'b0, b_exp_i};
    a_ext  = OW'($signed(a_i));
    a_dbl  = a_ext << 1;
    pp_o   = '0;
    corr_o = '0;
    mag    = '0;
    pp     = '0;
    neg    = 1'b0;
    code   = BoothZero;
    for (int unsigned d = 0; d < NDig; d++) begin
      code = booth_decode(b_pad[2*d +: 3]);
      unique case (code)
        BoothP1: begin mag = a_ext; neg = 1'b0; end
        BoothM1: begin mag = a_ext; neg = 1'b1; end
        BoothP2: begin mag = a_dbl; neg = 1'b0; end
        BoothM2: begin mag = a_dbl; neg = 1'b1; end
        default: begin mag = '0;    neg = 1'b0; end
      endcase
      pp = neg ? ~mag : mag;
      pp_o[d*OW +: OW] = (pp << (2 * d)) << shamt;
      // -x == ~x + 1; the +1 lands at this digit's weight after the shift
      if (neg) begin
        corr_o = corr_o | ((OW'(1) << (2 * d)) << shamt);
      end
    end
  end

endmodule

// File: rtl/bm_dot_acc.sv
// Block-minifloat dot-product accumulator: three-stage pipeline (operand register, Booth/CSA
// beat reduction, exact accumulate) with valid/ready on both sides.
// Optional BM_DOT_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module bm_dot_acc
  import bm_mac_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned MW      = 6,
  parameter int unsigned EW      = 2,
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned ACC_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*MW-1:0]   a_dat,
  input  logic [LANES*MW-1:0]   b_dat,
  input  logic [LANES*EW-1:0]   a_exp,
  input  logic [LANES*EW-1:0]   b_exp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_dat,
  output logic                  out_ovf
);

  localparam int unsigned NDig = booth_digits(MW);
  localparam int unsigned MinW = min_acc_w(MW, EW, LANES, MAX_LEN);
  // Beat reduction is never narrower than what one beat needs
  localparam int unsigned CsaW = (ACC_W > MinW) ? ACC_W : MinW;
  localparam int unsigned Msb  = ACC_W - 1;

  logic stall;

  // S1 state
  logic                s1_valid_q, s1_last_q;
  logic [LANES*MW-1:0] s1_a_q, s1_b_q;
  logic [LANES*EW-1:0] s1_ea_q, s1_eb_q;

  // S2 state
  logic               s2_valid_q, s2_last_q;
  logic [ACC_W-1:0]   s2_sum_q;

  // S3 state
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               first_q, first_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_dat_q, out_dat_d;
  logic               out_ovf_q, out_ovf_d;

  logic [LANES-1:0][NDig*CsaW-1:0] lane_pp;
  logic [LANES-1:0][CsaW-1:0]      lane_corr;
  logic [CsaW-1:0] csa_s, csa_c, csa_t, csa_x, beat_full;

  logic [ACC_W-1:0] acc_base, acc_sum, acc_new;
  logic             ovf_base, add_ovf, ovf_new;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign out_dat   = out_dat_q;
  assign out_ovf   = out_ovf_q;

  // S1: capture accepted operands; a missing beat becomes a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ea_q    <= '0;
      s1_eb_q    <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_valid && in_last;
      if (in_valid) begin
        s1_a_q  <= a_dat;
        s1_b_q  <= b_dat;
        s1_ea_q <= a_exp;
        s1_eb_q <= b_exp;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bm_booth_lane #(
      .MW (MW),
      .EW (EW),
      .OW (CsaW)
    ) u_lane (
      .a_i     (s1_a_q[lane_lsb(l, MW) +: MW]),
      .b_i     (s1_b_q[lane_lsb(l, MW) +: MW]),
      .a_exp_i (s1_ea_q[lane_lsb(l, EW) +: EW]),
      .b_exp_i (s1_eb_q[lane_lsb(l, EW) +: EW]),
      .pp_o    (lane_pp[l]),
      .corr_o  (lane_corr[l])
    );
  end

  // Carry-save fold of every partial product and correction word, one final carry-propagate add
  always_comb begin
    csa_s = '0;
    csa_c = '0;
    csa_t = '0;
    csa_x = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned d = 0; d <= NDig; d++) begin
        csa_x = (d < NDig) ? lane_pp[l][d*CsaW +: CsaW] : lane_corr[l];
        csa_t = csa_s ^ csa_c ^ csa_x;
        csa_c = ((csa_s & csa_c) | (csa_s & csa_x) | (csa_c & csa_x)) << 1;
        csa_s = csa_t;
      end
    end
    beat_full = csa_s + csa_c;
  end

  if (CsaW > ACC_W) begin : g_beat_trunc
    logic beat_unused;
    assign beat_unused = ^beat_full[CsaW-1:ACC_W];
  end

  // S2: register the reduced beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_sum_q   <= '0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_sum_q   <= beat_full[ACC_W-1:0];
    end
  end

  // S3: accumulate, restart after a last beat, publish the result
  always_comb begin
    acc_base = first_q ? '0 : acc_q;
    ovf_base = !first_q && ovf_q;
    acc_sum  = acc_base + s2_sum_q;
    add_ovf  = (acc_base[Msb] == s2_sum_q[Msb]) && (acc_sum[Msb] != acc_base[Msb]);
`ifdef BM_DOT_ACC_SAT_EN
    // Once clamped, hold the clamp until the result leaves
    if (ovf_base) begin
      acc_new = acc_base;
    end else if (add_ovf) begin
      acc_new = acc_base[Msb] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_new = acc_sum;
    end
`else
    acc_new = acc_sum;
`endif
    ovf_new = ovf_base || add_ovf;

    acc_d       = acc_q;
    ovf_d       = ovf_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_dat_d   = out_dat_q;
    out_ovf_d   = out_ovf_q;
    if (!stall) begin
      out_valid_d = 1'b0;
      if (s2_valid_q) begin
        acc_d   = acc_new;
        ovf_d   = ovf_new;
        first_d = s2_last_q;
        if (s2_last_q) begin
          out_valid_d = 1'b1;
          out_dat_d   = acc_new;
          out_ovf_d   = ovf_new;
        end
      end
    end
  end

  // S3 and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_dat_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_dat_q   <= out_dat_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_bm_dot_acc.sv
// Scoreboard bench for bm_dot_acc: a 32-bit accumulator instance under random and directed
// beats, plus a 20-bit instance driven into overflow. Honours BM_DOT_ACC_SAT_EN when defined.
module tb_bm_dot_acc;

  localparam int unsigned L  = 4;
  localparam int unsigned M  = 6;
  localparam int unsigned E  = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned WS = 20;
`ifdef BM_DOT_ACC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  typedef struct {
    longint dat;
    bit     ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;

  logic           in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [L*M-1:0] a_dat, b_dat;
  logic [L*E-1:0] a_exp, b_exp;
  logic [W-1:0]   out_dat;

  logic           s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_ovf;
  logic [L*M-1:0] s_a_dat, s_b_dat;
  logic [L*E-1:0] s_a_exp, s_b_exp;
  logic [WS-1:0]  s_out_dat;

  res_t   exp_q[$];
  res_t   exp_s_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint m_acc[2];
  bit     m_ovf[2];
  int     rdy_mode = 0;
  int     stall_waits = 0;

  always #5 clk = ~clk;

  bm_dot_acc #(
    .LANES (L), .MW (M), .EW (E), .MAX_LEN (256), .ACC_W (W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a_dat     (a_dat),
    .b_dat     (b_dat),
    .a_exp     (a_exp),
    .b_exp     (b_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dat   (out_dat),
    .out_ovf   (out_ovf)
  );

  bm_dot_acc #(
    .LANES (L), .MW (M), .EW (E), .MAX_LEN (256), .ACC_W (WS)
  ) u_dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_last   (s_in_last),
    .a_dat     (s_a_dat),
    .b_dat     (s_b_dat),
    .a_exp     (s_a_exp),
    .b_exp     (s_b_exp),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_dat   (s_out_dat),
    .out_ovf   (s_out_ovf)
  );

  function automatic void cmp(string name, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Exact beat value: sum of a*b*2^(ea+eb) over lanes
  function automatic longint beat_val(logic [L*M-1:0] a, logic [L*M-1:0] b,
                                      logic [L*E-1:0] ea, logic [L*E-1:0] eb);
    longint s = 0;
    for (int i = 0; i < L; i++) begin
      s += longint'($signed(a[i*M +: M])) * longint'($signed(b[i*M +: M]))
           * (longint'(1) << (int'(ea[i*E +: E]) + int'(eb[i*E +: E])));
    end
    return s;
  endfunction

  // Reference accumulator of width w; pushes the expected result on a last beat
  function automatic void model_beat(int id, longint beat, bit last);
    int     w  = (id == 0) ? W : WS;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -hi - 1;
    longint ex;
    res_t   r;
    if (!(Sat && m_ovf[id])) begin
      ex = m_acc[id] + beat;
      if (ex > hi || ex < lo) begin
        m_ovf[id] = 1'b1;
        if (Sat) begin
          ex = (ex > hi) ? hi : lo;
        end else begin
          ex = ex & ((longint'(1) <<< w) - 1);
          if (ex > hi) ex -= (longint'(1) <<< w);
        end
      end
      m_acc[id] = ex;
    end
    if (last) begin
      r.dat = m_acc[id];
      r.ovf = m_ovf[id];
      if (id == 0) exp_q.push_back(r);
      else         exp_s_q.push_back(r);
      m_acc[id] = 0;
      m_ovf[id] = 1'b0;
    end
  endfunction

  function automatic logic [L*M-1:0] rep_m(int v);
    logic [L*M-1:0] r;
    for (int i = 0; i < L; i++) r[i*M +: M] = M'(v);
    return r;
  endfunction

  function automatic logic [L*E-1:0] rep_e(int v);
    logic [L*E-1:0] r;
    for (int i = 0; i < L; i++) r[i*E +: E] = E'(v);
    return r;
  endfunction

  function automatic logic [L*M-1:0] lane0_m(int v);
    logic [L*M-1:0] r = '0;
    r[M-1:0] = M'(v);
    return r;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one beat on the main DUT; model it at the accepting edge
  task automatic send(input logic [L*M-1:0] a, input logic [L*M-1:0] b,
                      input logic [L*E-1:0] ea, input logic [L*E-1:0] eb, input bit last);
    int waited = 0;
    a_dat = a; b_dat = b; a_exp = ea; b_exp = eb; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    stall_waits += waited;
    @(posedge clk);
    if (waited < 200) begin
      model_beat(0, beat_val(a, b, ea, eb), last);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: waited %0d cycles, required < 200", waited);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_s(input logic [L*M-1:0] a, input logic [L*M-1:0] b,
                        input logic [L*E-1:0] ea, input logic [L*E-1:0] eb, input bit last);
    s_a_dat = a; s_b_dat = b; s_a_exp = ea; s_b_exp = eb; s_in_last = last; s_in_valid = 1'b1;
    @(negedge clk);
    cmp("small_in_ready", longint'(s_in_ready), 1);
    @(posedge clk);
    model_beat(1, beat_val(a, b, ea, eb), last);
    #1;
    s_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_acc = '{0, 0};
    m_ovf = '{1'b0, 1'b0};
    exp_q.delete();
    exp_s_q.delete();
    @(posedge clk);
    @(negedge clk);
    cmp("rst_in_ready", longint'(in_ready), 1);
    cmp("rst_out_valid", longint'(out_valid), 0);
    cmp("rst_out_dat", longint'(out_dat), 0);
    cmp("rst_out_ovf", longint'(out_ovf), 0);
    #1;
  endtask

  task automatic drain(int budget);
    int k = 0;
    while ((exp_q.size() != 0 || exp_s_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    cmp("drain_pending", exp_q.size() + exp_s_q.size(), 0);
    sync();
  endtask

  // Main scoreboard monitor
  always @(negedge clk) begin
    res_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_result", longint'($signed(out_dat)), -1);
      end else begin
        e = exp_q.pop_front();
        cmp("dot_dat", longint'($signed(out_dat)), e.dat);
        cmp("dot_ovf", longint'(out_ovf), longint'(e.ovf));
      end
    end
  end

  // Narrow-accumulator monitor
  always @(negedge clk) begin
    res_t e;
    if (rst_n && s_out_valid && s_out_ready) begin
      if (exp_s_q.size() == 0) begin
        cmp("small_unexpected_result", longint'($signed(s_out_dat)), -1);
      end else begin
        e = exp_s_q.pop_front();
        cmp("small_dat", longint'($signed(s_out_dat)), e.dat);
        cmp("small_ovf", longint'(s_out_ovf), longint'(e.ovf));
      end
    end
  end

  // Output back-pressure: 0 always ready, 1 random, other values hold off
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_low;
    int len;
    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; a_dat = '0; b_dat = '0; a_exp = '0; b_exp = '0;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_a_dat = '0; s_b_dat = '0;
    s_a_exp = '0; s_b_exp = '0; s_out_ready = 1'b1;
    do_reset();

    // Single lane product and three-cycle latency
    sync();
    send(lane0_m(5), lane0_m(3), '0, '0, 1'b1);
    @(negedge clk); cmp("lat_cycle1", longint'(out_valid), 0);
    @(negedge clk); cmp("lat_cycle2", longint'(out_valid), 0);
    @(negedge clk); cmp("lat_cycle3", longint'(out_valid), 1);
    sync();

    // Extreme negative mantissas with maximum shift
    send(rep_m(-32), rep_m(-32), rep_e(3), rep_e(3), 1'b1);

    // 256 back-to-back beats, no stall expected
    stall_waits = 0;
    for (int i = 0; i < 256; i++) send(rep_m(31), rep_m(31), rep_e(3), rep_e(3), i == 255);
    cmp("b2b_stall_cycles", stall_waits, 0);
    drain(100);

    // Three single-beat results held off for six cycles
    rdy_mode = 2;
    sync();
    sync();
    fork
      begin
        send(lane0_m(1), lane0_m(1), '0, '0, 1'b1);
        send(lane0_m(-2), lane0_m(1), '0, '0, 1'b1);
        send(lane0_m(3), lane0_m(1), '0, '0, 1'b1);
      end
      begin
        seen_low = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (!in_ready) seen_low = 1'b1;
        end
        cmp("bp_in_ready_dropped", longint'(seen_low), 1);
        cmp("bp_valid_held", longint'(out_valid), 1);
        cmp("bp_dat_held", longint'($signed(out_dat)), 1);
        rdy_mode = 0;
      end
    join
    drain(100);

    // Abort a dot product with reset, then a fresh single beat
    for (int i = 0; i < 10; i++) begin
      send((L*M)'($urandom()), (L*M)'($urandom()), (L*E)'($urandom()), (L*E)'($urandom()),
           1'b0);
    end
    do_reset();
    sync();
    send(lane0_m(2), lane0_m(2), '0, '0, 1'b1);
    drain(100);

    // Random dot products under random back-pressure and input gaps
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) sync();
        send((L*M)'($urandom()), (L*M)'($urandom()), (L*E)'($urandom()),
             (L*E)'($urandom()), j == len - 1);
      end
    end
    drain(3000);
    rdy_mode = 0;

    // Narrow accumulator driven into overflow
    for (int i = 0; i < 20; i++) send_s(rep_m(31), rep_m(31), rep_e(3), rep_e(3), i == 19);
    drain(100);

    cmp("main_queue_left", exp_q.size(), 0);
    cmp("small_queue_left", exp_s_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bm_dot_acc.md
Name: bm_dot_acc

Overview:
- Parametrised successor to the single-shot fp(2,5) Booth multiply-add.
- Computes an N-lane block-minifloat dot product per beat (signed mantissa × signed mantissa, shifted by the exponent sum) and reduces all lanes per beat.
- Accumulates beats exactly (Kulisch style) until a beat tagged last, then emits the sum with a valid/ready handshake.
- Sits between the operand fetch/unpack stage and the output requantiser in the BM MAC datapath.

Parameters:
- LANES, 4, products summed per beat
- MW, 6, mantissa width in bits, two's complement, sign included
- EW, 2, exponent width; per-operand shift range 0..2^EW-1
- MAX_LEN, 256, maximum beats per dot product
- ACC_W, 32, accumulator width; must be ≥ 2*MW + 2*(2^EW-1) + clog2(LANES) + clog2(MAX_LEN)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  final beat of the current dot product
- a_dat  in  LANES*MW  lane mantissas A; lane i at [i*MW +: MW]
- b_dat  in  LANES*MW  lane mantissas B
- a_exp  in  LANES*EW  unsigned exponent per lane
- b_exp  in  LANES*EW  unsigned exponent per lane
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_dat  out  ACC_W  signed dot-product result
- out_ovf  out  1  accumulator overflowed during this result

Behaviour:
- Lane product: radix-4 Booth of a×b with b recoded, sign-extended, then shifted left by (a_exp+b_exp). Exact, no rounding.
- Pipeline, all three stages advance together on !stall:
  - S1: register operands and in_last.
  - S2: Booth partial products, shift, CSA reduction across all lanes; register beat sum (ACC_W, sign-extended) and last.
  - S3: acc <= acc_base + beat_sum, where acc_base = 0 if the previous S3 beat was last (or the first beat after reset), else acc.
- Handshake:
  - stall = out_valid && !out_ready; in_ready = !stall.
  - Bubbles (no valid beat) propagate through the stages and do not touch acc.
- Output:
  - When a last beat completes S3: out_valid=1, out_dat=final sum.
  - out_dat and out_valid hold stable while stalled.
  - out_valid drops the cycle after the handshake unless another last beat completes S3 in that same cycle.
- Latency: last beat accepted at cycle t → out_valid at t+3 with no stall.
- Throughput: one beat per cycle; back-to-back dot products need no gap. A single-beat dot product (in_last on its first beat) is legal.
- Overflow:
  - out_ovf is set if any S3 add of the current dot product overflows signed ACC_W (sign of result differs from both equal operand signs).
  - The flag is sticky until the result is emitted; the value wraps.
- Beats beyond MAX_LEN without last: no error; correctness is limited by ACC_W.
- Reset (any time, including mid-dot-product): all pipeline valids=0, acc=0, out_valid=0, out_dat=0, out_ovf=0, in_ready=1 on the first clock after release. A partial dot product is discarded.
- Simultaneous last-beat completion and out handshake: the new result is loaded; no bubble.

Optional Feature:
- BM_DOT_ACC_SAT_EN
- Defined: on overflow, acc clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) (direction from the operand signs) and stays clamped until the result is emitted; out_ovf is still reported.
- Undefined: wrap-around as above.

Decomposition:
- Shared package bm_mac_pkg:
  - width functions: product width 2*MW, shifted width 2*MW+2*(2^EW-1), min ACC_W;
  - Booth code enum (ZERO, P1, M1, P2, M2);
  - lane slice helpers.
- One combinational sub-module bm_booth_lane: one lane's Booth recode, partial-product generation and shift; output shifted product plus correction bits for the CSA.

Test Plan:
- Lane0 a=5, b=3, exps 0; other lanes 0; in_last=1, out_ready=1 → out_valid 3 cycles later, out_dat=15, out_ovf=0.
- All lanes a=-32, b=-32, a_exp=3, b_exp=3, single beat → out_dat=4×1024×64=262144.
- 256 beats, all lanes a=31, b=31, exps 3, last on beat 256 → out_dat=62980096; back-to-back, in_ready stays 1.
- Three one-beat dot products (results 1, -2, 3) with out_ready=0 for 6 cycles → in_ready drops, out_dat holds 1; after release, results 1, -2, 3 in order with no loss.
- Assert rst_n low after 10 of 20 beats; restart with a single beat a=2, b=2 → out_dat=4, with no residue from the aborted sum.
- ACC_W=20, 20 beats all lanes 31×31 <<6 → out_ovf=1; value wraps without BM_DOT_ACC_SAT_EN and equals 524287 with it.
